// File: rtl/alarm_bank.sv
// alarm_bank: multi-channel alarm controller.
// Holds N_ALARMS programmable alarm times, compares them against the running
// seconds time stamp and drives a single ring output. Alarms that fire while
// another one is being serviced are queued in `pending` and served lowest
// index first once the controller is idle again.
module alarm_bank #(
  parameter int N_ALARMS    = 4,
  parameter int TS_W        = 64,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int IDX_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TS_W-1:0]     time_stamp,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [TS_W-1:0]     cfg_time,
  input  logic                cfg_en,
  input  logic                snooze,
  input  logic                stop,
  output logic                ring,
  output logic                snoozed,
  output logic [IDX_W-1:0]    ring_idx,
  output logic [N_ALARMS-1:0] pending
);

  // Counter widths are sized so the terminal values are representable.
  localparam int RC_W = (RING_SECS > 0) ? $clog2(RING_SECS + 1) : 1;
  localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [RC_W-1:0] RING_LIMIT = RC_W'(RING_SECS);
  localparam logic [SC_W-1:0] SNZ_LIMIT  = SC_W'(MAX_SNOOZE);
  localparam logic [TS_W-1:0] SNZ_LEN    = TS_W'(SNOOZE_SECS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZED = 2'd2
  } state_e;

  // Per-channel configuration
  logic [TS_W-1:0]     alarm_time_q [N_ALARMS];
  logic [N_ALARMS-1:0] en_q;

  // Tick detection
  logic [TS_W-1:0]     ts_prev_q;
  logic                ts_valid_q;
  logic                tick;

  // Controller state
  state_e              state_q;
  logic [RC_W-1:0]     ring_cnt_q;
  logic [SC_W-1:0]     snz_cnt_q;
  logic [TS_W-1:0]     snz_start_q;
  logic                ring_q;
  logic                snoozed_q;
  logic [IDX_W-1:0]    ring_idx_q;
  logic [N_ALARMS-1:0] pending_q;
  logic [N_ALARMS-1:0] pending_d;

  // Combinational helpers
  logic [N_ALARMS-1:0] fire;
  logic [N_ALARMS-1:0] cfg_hit;
  logic [N_ALARMS-1:0] cand;
  logic [N_ALARMS-1:0] grant_oh;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  logic [TS_W-1:0]     snz_elapsed;
  logic                wake;
  logic                snz_allowed;
  logic [RC_W-1:0]     ring_cnt_inc;

  // A tick is any change of the time stamp; the first cycle after reset has
  // no valid previous value and never counts as a tick.
  assign tick = ts_valid_q && (time_stamp != ts_prev_q);

  // Unsigned wrap-around difference: a backward time jump yields a huge value
  // and therefore wakes a snoozed alarm at once.
  assign snz_elapsed  = time_stamp - snz_start_q;
  assign wake         = (snz_elapsed >= SNZ_LEN);
  assign snz_allowed  = (snz_cnt_q < SNZ_LIMIT);
  assign ring_cnt_inc = ring_cnt_q + RC_W'(1);

  // Per-channel equality match and config-write decode (out-of-range
  // indices match no channel and are therefore dropped).
  always_comb begin
    fire    = '0;
    cfg_hit = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      fire[i]    = tick && en_q[i] && (time_stamp == alarm_time_q[i]);
      cfg_hit[i] = cfg_we && (cfg_idx == IDX_W'(i));
    end
  end

  // Lowest-index selection among queued and freshly firing channels.
  always_comb begin
    cand      = pending_q | fire;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
        grant_oh  = N_ALARMS'(1) << i;
      end
    end
  end

  // Pending queue: fires always enqueue, the channel taken from idle is
  // removed, and a configuration write discards that channel's request.
  always_comb begin
    pending_d = pending_q | fire;
    if ((state_q == S_IDLE) && grant_vld) begin
      pending_d = pending_d & ~grant_oh;
    end
    pending_d = pending_d & ~cfg_hit;
  end

  // Channel configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        alarm_time_q[i] <= '0;
      end
      en_q <= '0;
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (cfg_hit[i]) begin
          alarm_time_q[i] <= cfg_time;
          en_q[i]         <= cfg_en;
        end
      end
    end
  end

  // Previous time stamp; only the valid flag needs a reset value.
  always_ff @(posedge clk) begin
    ts_prev_q <= time_stamp;
    if (rst) begin
      ts_valid_q <= 1'b0;
    end else begin
      ts_valid_q <= 1'b1;
    end
  end

  // Ring controller: IDLE / RINGING / SNOOZED with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ring_q      <= 1'b0;
      snoozed_q   <= 1'b0;
      ring_idx_q  <= '0;
      pending_q   <= '0;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      snz_start_q <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            state_q    <= S_RINGING;
            ring_q     <= 1'b1;
            snoozed_q  <= 1'b0;
            ring_idx_q <= grant_idx;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
          end
        end
        S_RINGING: begin
          if (stop || (snooze && !snz_allowed)) begin
            // Stop wins over snooze; an exhausted snooze budget acts as stop.
            state_q    <= S_IDLE;
            ring_q     <= 1'b0;
            ring_idx_q <= '0;
          end else if (snooze) begin
            state_q     <= S_SNOOZED;
            ring_q      <= 1'b0;
            snoozed_q   <= 1'b1;
            snz_start_q <= time_stamp;
            snz_cnt_q   <= snz_cnt_q + SC_W'(1);
          end else if (tick) begin
            ring_cnt_q <= ring_cnt_inc;
            if (ring_cnt_inc >= RING_LIMIT) begin
              state_q    <= S_IDLE;
              ring_q     <= 1'b0;
              ring_idx_q <= '0;
            end
          end
        end
        S_SNOOZED: begin
          if (stop) begin
            state_q    <= S_IDLE;
            snoozed_q  <= 1'b0;
            ring_idx_q <= '0;
          end else if (wake) begin
            state_q    <= S_RINGING;
            ring_q     <= 1'b1;
            snoozed_q  <= 1'b0;
            ring_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          ring_q     <= 1'b0;
          snoozed_q  <= 1'b0;
          ring_idx_q <= '0;
        end
      endcase
    end
  end

  assign ring     = ring_q;
  assign snoozed  = snoozed_q;
  assign ring_idx = ring_idx_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Testbench for alarm_bank: table-driven directed vectors, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_alarm_bank;

  localparam int NA     = 4;
  localparam int RING_S = 60;
  localparam int SNZ_S  = 300;
  localparam int MAXSNZ = 3;

  logic        clk;
  logic        rst;
  logic [63:0] time_stamp;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [63:0] cfg_time;
  logic        cfg_en;
  logic        snooze;
  logic        stop;
  logic        ring;
  logic        snoozed;
  logic [2:0]  ring_idx;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Index port widened to 3 bits so that out-of-range channel numbers exist.
  alarm_bank #(
    .N_ALARMS(NA), .TS_W(64), .RING_SECS(RING_S), .SNOOZE_SECS(SNZ_S),
    .MAX_SNOOZE(MAXSNZ), .IDX_W(3)
  ) dut (
    .clk(clk), .rst(rst), .time_stamp(time_stamp), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_time(cfg_time), .cfg_en(cfg_en),
    .snooze(snooze), .stop(stop), .ring(ring), .snoozed(snoozed),
    .ring_idx(ring_idx), .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural reference model ----------------
  logic [63:0] m_alarm [NA];
  bit          m_en    [NA];
  bit   [3:0]  m_pend;
  int          m_active;     // -1 when no alarm event is in progress
  bit          m_snz;
  int          m_left;       // ring seconds remaining
  int          m_used;       // snoozes used in this event
  logic [63:0] m_start;
  logic [63:0] m_prev;
  bit          m_have_prev;

  task automatic model_step();
    bit tk;
    int k;
    if (rst) begin
      for (int i = 0; i < NA; i++) begin
        m_alarm[i] = '0;
        m_en[i]    = 1'b0;
      end
      m_pend = '0; m_active = -1; m_snz = 1'b0; m_left = 0; m_used = 0;
      m_start = '0; m_have_prev = 1'b0; m_prev = time_stamp;
      return;
    end
    tk = m_have_prev && (time_stamp != m_prev);
    for (int i = 0; i < NA; i++)
      if (tk && m_en[i] && time_stamp == m_alarm[i]) m_pend[i] = 1'b1;
    if (m_active < 0) begin
      k = -1;
      for (int i = NA - 1; i >= 0; i--) if (m_pend[i]) k = i;
      if (k >= 0) begin
        m_pend[k] = 1'b0; m_active = k; m_left = RING_S; m_used = 0; m_snz = 1'b0;
      end
    end else if (stop) begin
      m_active = -1;
    end else if (!m_snz) begin
      if (snooze) begin
        if (m_used < MAXSNZ) begin
          m_snz = 1'b1; m_start = time_stamp; m_used++;
        end else begin
          m_active = -1;
        end
      end else if (tk) begin
        m_left--;
        if (m_left == 0) m_active = -1;
      end
    end else if (time_stamp - m_start >= 64'(SNZ_S)) begin
      m_snz = 1'b0; m_left = RING_S;
    end
    if (m_active < 0) m_snz = 1'b0;
    if (cfg_we && cfg_idx < 3'(NA)) begin
      m_alarm[cfg_idx] = cfg_time;
      m_en[cfg_idx]    = cfg_en;
      m_pend[cfg_idx]  = 1'b0;
    end
    m_prev = time_stamp;
    m_have_prev = 1'b1;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit r, input bit s,
                           input logic [2:0] i, input logic [3:0] p);
    chk({tag, " ring"}, 64'(ring), 64'(r));
    chk({tag, " snoozed"}, 64'(snoozed), 64'(s));
    chk({tag, " ring_idx"}, 64'(ring_idx), 64'(i));
    chk({tag, " pending"}, 64'(pending), 64'(p));
  endtask

  // One clock: the model consumes the same inputs the DUT samples, outputs
  // are then observed 1 time unit after the edge and pulses are dropped.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    snooze = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [63:0] t, input bit en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_time = t; cfg_en = en;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [63:0] ts;
    bit          we;
    logic [2:0]  idx;
    logic [63:0] t;
    bit          en;
    bit          snz;
    bit          stp;
    int          n;
    bit          e_ring;
    bit          e_snz;
    logic [2:0]  e_idx;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [63:0] ts, bit we, logic [2:0] idx, logic [63:0] t,
                              bit en, bit snz, bit stp, int n, bit er, bit es,
                              logic [2:0] ei, logic [3:0] ep);
    vec_t v;
    v.ts = ts; v.we = we; v.idx = idx; v.t = t; v.en = en; v.snz = snz; v.stp = stp;
    v.n = n; v.e_ring = er; v.e_snz = es; v.e_idx = ei; v.e_pend = ep;
    return v;
  endfunction

  logic [63:0] st;
  int          r;

  initial begin
    rst = 1'b1; time_stamp = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_time = '0;
    cfg_en = 1'b0; snooze = 1'b0; stop = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check_out("reset", 0, 0, 0, 4'b0000);

    //        ts   we idx  t    en snz stp n   ring snz idx pend
    tbl.push_back(mk( 98, 1, 1, 100, 1, 0, 0, 1,  0, 0, 0, 4'b0000));
    tbl.push_back(mk( 98, 0, 0,   0, 0, 0, 0, 9,  0, 0, 0, 4'b0000));
    tbl.push_back(mk( 99, 0, 0,   0, 0, 0, 0, 10, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(100, 0, 0,   0, 0, 0, 0, 1,  1, 0, 1, 4'b0000));
    tbl.push_back(mk(100, 0, 0,   0, 0, 0, 0, 9,  1, 0, 1, 4'b0000));
    tbl.push_back(mk(101, 0, 0,   0, 0, 0, 0, 10, 1, 0, 1, 4'b0000));
    tbl.push_back(mk(101, 0, 0,   0, 0, 0, 1, 1,  0, 0, 0, 4'b0000));
    // out-of-range channel write must not touch any channel
    tbl.push_back(mk(102, 1, 5, 103, 1, 0, 0, 1,  0, 0, 0, 4'b0000));
    tbl.push_back(mk(103, 0, 0,   0, 0, 0, 0, 2,  0, 0, 0, 4'b0000));
    tbl.push_back(mk(100, 0, 0,   0, 0, 0, 0, 1,  1, 0, 1, 4'b0000));
    tbl.push_back(mk(100, 0, 0,   0, 0, 0, 1, 1,  0, 0, 0, 4'b0000));
    // simultaneous fire of ch0 and ch2
    tbl.push_back(mk( 40, 1, 0,  50, 1, 0, 0, 1,  0, 0, 0, 4'b0000));
    tbl.push_back(mk( 41, 1, 2,  50, 1, 0, 0, 1,  0, 0, 0, 4'b0000));
    tbl.push_back(mk( 49, 0, 0,   0, 0, 0, 0, 2,  0, 0, 0, 4'b0000));
    tbl.push_back(mk( 50, 0, 0,   0, 0, 0, 0, 1,  1, 0, 0, 4'b0100));
    tbl.push_back(mk( 51, 0, 0,   0, 0, 0, 1, 1,  0, 0, 0, 4'b0100));
    tbl.push_back(mk( 51, 0, 0,   0, 0, 0, 0, 1,  1, 0, 2, 4'b0000));
    tbl.push_back(mk( 51, 0, 0,   0, 0, 0, 1, 1,  0, 0, 0, 4'b0000));

    foreach (tbl[k]) begin
      time_stamp = tbl[k].ts;
      if (tbl[k].we) cfg_write(tbl[k].idx, tbl[k].t, tbl[k].en);
      snooze = tbl[k].snz;
      stop   = tbl[k].stp;
      for (int c = 0; c < tbl[k].n; c++) cyc();
      check_out($sformatf("vec%0d", k), tbl[k].e_ring, tbl[k].e_snz, tbl[k].e_idx, tbl[k].e_pend);
    end

    // Snooze limit: three snoozes re-ring after SNZ_S seconds, fourth stops.
    time_stamp = 60; cfg_write(3, 200, 1); cyc();
    time_stamp = 199; cyc();
    time_stamp = 200; cyc();
    check_out("snz ring", 1, 0, 3, 4'b0000);
    st = 200;
    for (int k = 0; k < MAXSNZ; k++) begin
      snooze = 1'b1; cyc();
      check_out($sformatf("snz%0d enter", k), 0, 1, 3, 4'b0000);
      time_stamp = st + 299; cyc();
      check_out($sformatf("snz%0d hold", k), 0, 1, 3, 4'b0000);
      time_stamp = st + 300; cyc();
      check_out($sformatf("snz%0d wake", k), 1, 0, 3, 4'b0000);
      st = st + 300;
    end
    snooze = 1'b1; cyc();
    check_out("snz limit", 0, 0, 0, 4'b0000);

    // Automatic timeout after RING_S ticks.
    cfg_write(3, 1000, 1); cyc();
    time_stamp = 1000; cyc();
    check_out("tmo start", 1, 0, 3, 4'b0000);
    for (int t = 1001; t <= 1059; t++) begin
      time_stamp = 64'(t); cyc();
    end
    check_out("tmo 59", 1, 0, 3, 4'b0000);
    time_stamp = 1060; cyc();
    check_out("tmo 60", 0, 0, 0, 4'b0000);

    // Jump over an alarm time: no fire.
    cfg_write(0, 120, 1); cyc();
    time_stamp = 99; cyc();
    time_stamp = 150; cyc(); cyc(); cyc();
    check_out("jump", 0, 0, 0, 4'b0000);

    // stop and snooze together: stop wins.
    time_stamp = 120; cyc();
    check_out("both ring", 1, 0, 0, 4'b0000);
    stop = 1'b1; snooze = 1'b1; cyc();
    check_out("both stop", 0, 0, 0, 4'b0000);
    cyc();
    check_out("both idle", 0, 0, 0, 4'b0000);

    // Backward jump while snoozed wakes immediately.
    cfg_write(2, 300, 1); cyc();
    time_stamp = 300; cyc();
    check_out("back ring", 1, 0, 2, 4'b0000);
    snooze = 1'b1; cyc();
    check_out("back snz", 0, 1, 2, 4'b0000);
    time_stamp = 290; cyc();
    check_out("back wake", 1, 0, 2, 4'b0000);
    stop = 1'b1; cyc();

    // Reset mid-ring with a queued alarm; everything disabled afterwards.
    time_stamp = 300; cyc();
    time_stamp = 100; cyc();
    check_out("rst pre", 1, 0, 2, 4'b0010);
    rst = 1'b1; cyc();
    check_out("rst now", 0, 0, 0, 4'b0000);
    rst = 1'b0;
    time_stamp = 5; cyc();
    time_stamp = 100; cyc();
    time_stamp = 300; cyc();
    check_out("rst after", 0, 0, 0, 4'b0000);

    // Randomized run against the reference model.
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) time_stamp = 64'($urandom_range(0, 127));
      else if (r < 90) time_stamp = time_stamp + 64'd1;
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0)
        cfg_write(3'($urandom_range(0, 7)), 64'($urandom_range(0, 127)), $urandom_range(0, 3) != 0);
      snooze = ($urandom_range(0, 19) == 0);
      stop   = ($urandom_range(0, 29) == 0);
      cyc();
      rst = 1'b0;
      check_out($sformatf("rnd%0d", c), (m_active >= 0) && !m_snz, m_snz,
                (m_active < 0) ? 3'd0 : 3'(m_active), m_pend);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel alarm controller: the parametrised successor of the single-alarm block in the digital clock. It holds `N_ALARMS` programmable alarm times and compares them against the running seconds time stamp. It drives one ring output with snooze, stop, auto-timeout and queued service of alarms that fire simultaneously or while another is active. It sits between the timekeeping counter and the buzzer/display logic.

## Interface
- `N_ALARMS`, 4: number of alarm channels (≥1); `IDX_W = max(1, clog2(N_ALARMS))`
- `TS_W`, 64: time stamp width, in seconds
- `RING_SECS`, 60: seconds of ringing before automatic stop
- `SNOOZE_SECS`, 300: snooze length in seconds
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `time_stamp`  in  TS_W  current time in seconds; normally +1 per second, may jump when the user sets the time
- `cfg_we`  in  1  write strobe for one channel's configuration
- `cfg_idx`  in  IDX_W  channel written; indices ≥ N_ALARMS are ignored
- `cfg_time`  in  TS_W  alarm time written
- `cfg_en`  in  1  channel enable written
- `snooze`  in  1  single-cycle snooze request
- `stop`  in  1  single-cycle stop request
- `ring`  out  1  buzzer drive
- `snoozed`  out  1  active alarm is in snooze
- `ring_idx`  out  IDX_W  active channel; 0 when idle
- `pending`  out  N_ALARMS  channels that fired and are waiting for service

## Operation
- Per channel registers: `alarm_time[i]` and `en[i]`. They load on `cfg_we`. A write to a channel clears its `pending` bit. A write to the active channel does not end the current event.
- Tick detection: `ts_prev` and `ts_valid` registers. `tick = ts_valid && time_stamp != ts_prev`. `ts_valid` is 0 after reset and 1 from the next cycle on.
- Fire: `fire[i] = tick && en[i] && time_stamp == alarm_time[i]`. The comparison uses register contents from before any same-cycle write.
- Matching is by equality only. A time jump past an alarm time does not fire that alarm.
- State machine IDLE / RINGING / SNOOZED:
  - IDLE: if `pending | fire` is non-zero, take the lowest set index, load it into `ring_idx`, clear its pending bit, reset `ring_cnt` and `snz_cnt` to 0, and go to RINGING.
  - RINGING:
    - `stop` → IDLE.
    - `snooze` with `snz_cnt < MAX_SNOOZE` → SNOOZED: `snz_start = time_stamp`, `snz_cnt++`.
    - `snooze` with `snz_cnt == MAX_SNOOZE` → treated as stop.
    - Each tick increments `ring_cnt`. When it reaches RING_SECS → IDLE.
  - SNOOZED:
    - `stop` → IDLE.
    - `snooze` is ignored.
    - When `(time_stamp - snz_start) mod 2^TS_W ≥ SNOOZE_SECS` → RINGING with `ring_cnt = 0`. Because the difference is unsigned, a backward time jump wakes the alarm immediately.
- `stop` and `snooze` in the same cycle: stop wins. Both are ignored in IDLE.
- In RINGING/SNOOZED, every fire sets the `pending` bit of the firing channel, including the active channel.
- Return to IDLE always costs one cycle. The next pending channel starts ringing on the cycle after that.
- Reset: all alarm times 0, all enables 0, `pending` 0, state IDLE, `ring`, `snoozed` and `ring_idx` all 0, all counters 0.

## Timing
- All outputs are registered.
- `ring` rises one cycle after the cycle in which `time_stamp` first equals an enabled alarm time.
- `ring` falls one cycle after `stop`, after a snooze request, or after the tick that completes RING_SECS.
- `snoozed` and `ring` are never both 1.
- `ring_idx` is stable from the rise of `ring` until the return to IDLE.
- `pending` updates one cycle after the fire or `cfg_we` that changes it.
- A configuration write is visible to the compare logic on the next cycle.

## Test plan
- Basic: write ch1 time 100 enabled, step time_stamp 98→101 one value per 10 cycles → `ring`=1 one cycle after ts=100, `ring_idx`=1; `stop` → `ring`=0 next cycle, `pending`=0.
- Simultaneous: ch0 and ch2 both set to 50 → ch0 rings, `pending`=4'b0100. After `stop` there is one idle cycle, then ch2 rings and `pending`=0.
- Snooze limit: ring at 200, then `snooze` → `snoozed`=1, `ring`=0. At ts=500, `ring`=1 again. Repeat 3 times; a 4th `snooze` → IDLE.
- Timeout and jump: with RING_SECS=60 and no input, `ring` clears one cycle after ts=alarm+60. With ts jumping 99→150 over an alarm at 120, no fire occurs.
- Edge cases: `stop`+`snooze` in the same cycle → IDLE. Snoozed, then ts jumps backward → immediate re-ring. `rst` mid-ring → all outputs 0 next cycle, alarms disabled. `cfg_idx`=5 with N_ALARMS=4 → no change to any channel.
